// File: rtl/cube_frame_buffer_if.sv
// Pillar write, commit and swap handshakes between the pattern engine, the
// frame buffer and the pillar-scan display, plus the front-frame view.
interface cube_frame_buffer_if;
    logic         wr_valid;
    logic         wr_ready;
    logic [5:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         commit_valid;
    logic         commit_ready;
    logic         swap_sync;
    logic [511:0] frame_out;
    logic         swap_pending;
    logic [7:0]   frame_cnt;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_valid, swap_sync,
        input  wr_ready, commit_ready, frame_out, swap_pending, frame_cnt
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_valid, swap_sync,
        output wr_ready, commit_ready, frame_out, swap_pending, frame_cnt
    );
endinterface

// File: rtl/cube_frame_buffer.sv
// Double-buffered 64-pillar frame store for the 8x8x8 cube. Frames are built in
// the back bank and swapped to the front only on the display's wrap pulse.
module cube_frame_buffer #(
    parameter int PILLARS       = 64,
    parameter bit CLEAR_ON_SWAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    cube_frame_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        S_FILL,
        S_PENDING,
        S_CLEAR
    } state_t;

    state_t       r_state;
    state_t       w_nextState;
    logic         r_frontSel;
    logic [7:0]   r_frameCnt;
    logic [5:0]   r_clrCnt;
    logic [7:0]   r_bankA [0:PILLARS-1];
    logic [7:0]   r_bankB [0:PILLARS-1];

    logic         w_wrReady;
    logic         w_commitReady;
    logic         w_swapPending;
    logic         w_doSwap;
    logic         w_backWrEn;
    logic [5:0]   w_backAddr;
    logic [7:0]   w_backData;
    logic [511:0] w_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A commit accepted in FILL lands in PENDING, so a coincident swap_sync is never seen.
    always_comb begin
        w_nextState   = r_state;
        w_wrReady     = 1'b0;
        w_commitReady = 1'b0;
        w_swapPending = 1'b0;
        w_doSwap      = 1'b0;
        case (r_state)
            S_FILL: begin
                w_wrReady     = !rst;
                w_commitReady = !rst;
                if (bus.commit_valid && w_commitReady) begin
                    w_nextState = S_PENDING;
                end
            end
            S_PENDING: begin
                w_swapPending = 1'b1;
                if (bus.swap_sync) begin
                    w_doSwap    = 1'b1;
                    w_nextState = CLEAR_ON_SWAP ? S_CLEAR : S_FILL;
                end
            end
            S_CLEAR: begin
                if (r_clrCnt == 6'd63) begin
                    w_nextState = S_FILL;
                end
            end
            default: w_nextState = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frontSel <= 1'b0;
            r_frameCnt <= 8'd0;
            r_clrCnt   <= 6'd0;
        end else if (w_doSwap) begin
            r_frontSel <= ~r_frontSel;
            r_frameCnt <= r_frameCnt + 8'd1;
            r_clrCnt   <= 6'd0;
        end else if (r_state == S_CLEAR) begin
            r_clrCnt   <= r_clrCnt + 6'd1;
        end
    end

    // Only the back bank is ever addressed; the clear sweep reuses the write port.
    always_comb begin
        w_backWrEn = 1'b0;
        w_backAddr = bus.wr_addr;
        w_backData = bus.wr_data;
        if (r_state == S_CLEAR) begin
            w_backWrEn = 1'b1;
            w_backAddr = r_clrCnt;
            w_backData = 8'd0;
        end else if (r_state == S_FILL && bus.wr_valid) begin
            w_backWrEn = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PILLARS; p++) begin
                r_bankA[p] <= 8'd0;
                r_bankB[p] <= 8'd0;
            end
        end else if (w_backWrEn) begin
            if (r_frontSel) begin
                r_bankA[w_backAddr] <= w_backData;
            end else begin
                r_bankB[w_backAddr] <= w_backData;
            end
        end
    end

    always_comb begin
        w_frame = '0;
        for (int p = 0; p < PILLARS; p++) begin
            w_frame[8*p +: 8] = r_frontSel ? r_bankB[p] : r_bankA[p];
        end
    end

    assign bus.wr_ready     = w_wrReady;
    assign bus.commit_ready = w_commitReady;
    assign bus.swap_pending = w_swapPending;
    assign bus.frame_cnt    = r_frameCnt;
    assign bus.frame_out    = w_frame;

endmodule

// File: tb/tb_cube_frame_buffer.sv
// Directed bench for cube_frame_buffer: one clearing instance and one
// non-clearing instance sharing clock and reset.
module tb_cube_frame_buffer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cube_frame_buffer_if ifA ();
    cube_frame_buffer_if ifB ();

    cube_frame_buffer #(.PILLARS(64), .CLEAR_ON_SWAP(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifA.slave)
    );

    cube_frame_buffer #(.PILLARS(64), .CLEAR_ON_SWAP(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrA(input logic [5:0] addr, input logic [7:0] data);
        ifA.wr_valid = 1'b1;
        ifA.wr_addr  = addr;
        ifA.wr_data  = data;
        tick();
        ifA.wr_valid = 1'b0;
    endtask

    task automatic commitA();
        ifA.commit_valid = 1'b1;
        tick();
        ifA.commit_valid = 1'b0;
    endtask

    task automatic swapA();
        ifA.swap_sync = 1'b1;
        tick();
        ifA.swap_sync = 1'b0;
    endtask

    task automatic wrB(input logic [5:0] addr, input logic [7:0] data);
        ifB.wr_valid = 1'b1;
        ifB.wr_addr  = addr;
        ifB.wr_data  = data;
        tick();
        ifB.wr_valid = 1'b0;
    endtask

    task automatic commitSwapB();
        ifB.commit_valid = 1'b1;
        tick();
        ifB.commit_valid = 1'b0;
        tick();
        ifB.swap_sync = 1'b1;
        tick();
        ifB.swap_sync = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ifA.wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wr_ready: got %b expected 0", ifA.wr_ready);
        end
        checks++;
        if (ifA.commit_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_commit_ready: got %b expected 0", ifA.commit_ready);
        end
        checks++;
        if (ifA.frame_out !== 512'd0) begin
            errors++;
            $display("[TB] FAIL reset_frame: got %h expected 0", ifA.frame_out);
        end
        checks++;
        if (ifA.swap_pending !== 1'b0 || ifA.frame_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_status: got pend=%b cnt=%0d expected 0/0", ifA.swap_pending, ifA.frame_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ifA.wr_ready !== 1'b1 || ifA.commit_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_ready: got %b%b expected 11", ifA.wr_ready, ifA.commit_ready);
        end
    endtask

    task automatic test_fill_swap();
        logic [511:0] exp;
        int           lowCycles;
        exp = '0;
        for (int p = 0; p < 64; p++) begin
            wrA(6'(p), 8'(p));
            exp[8*p +: 8] = 8'(p);
        end
        commitA();
        checks++;
        if (ifA.swap_pending !== 1'b1 || ifA.wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL commit_pending: got pend=%b rdy=%b expected 1/0", ifA.swap_pending, ifA.wr_ready);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ifA.frame_out !== 512'd0) begin
            errors++;
            $display("[TB] FAIL pre_swap_frame: got %h expected 0", ifA.frame_out);
        end
        swapA();
        checks++;
        if (ifA.frame_out !== exp) begin
            errors++;
            $display("[TB] FAIL swap_frame: got %h expected %h", ifA.frame_out, exp);
        end
        checks++;
        if (ifA.frame_cnt !== 8'd1 || ifA.swap_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_status: got cnt=%0d pend=%b expected 1/0", ifA.frame_cnt, ifA.swap_pending);
        end
        lowCycles = 0;
        while (ifA.wr_ready !== 1'b1 && lowCycles < 100) begin
            tick();
            lowCycles++;
        end
        checks++;
        if (lowCycles != 64) begin
            errors++;
            $display("[TB] FAIL clear_duration: got %0d cycles expected 64", lowCycles);
        end
        checks++;
        if (ifA.frame_out !== exp) begin
            errors++;
            $display("[TB] FAIL frame_during_clear: got %h expected %h", ifA.frame_out, exp);
        end
    endtask

    // The bank holding 0..63 becomes back at swap 2 and must be wiped before swap 3.
    task automatic test_empty_commit();
        commitA();
        swapA();
        checks++;
        if (ifA.frame_out !== 512'd0 || ifA.frame_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL empty_swap2: got cnt=%0d frame=%h expected 2/0", ifA.frame_cnt, ifA.frame_out);
        end
        for (int i = 0; i < 64; i++) tick();
        commitA();
        swapA();
        checks++;
        if (ifA.frame_out !== 512'd0 || ifA.frame_cnt !== 8'd3) begin
            errors++;
            $display("[TB] FAIL cleared_swap3: got cnt=%0d frame=%h expected 3/0", ifA.frame_cnt, ifA.frame_out);
        end
        for (int i = 0; i < 64; i++) tick();
    endtask

    task automatic test_coincident();
        logic [511:0] exp;
        exp = '0;
        exp[8*5 +: 8] = 8'h12;
        ifA.wr_valid     = 1'b1;
        ifA.wr_addr      = 6'd5;
        ifA.wr_data      = 8'h12;
        ifA.commit_valid = 1'b1;
        ifA.swap_sync    = 1'b1;
        tick();
        ifA.wr_valid     = 1'b0;
        ifA.commit_valid = 1'b0;
        ifA.swap_sync    = 1'b0;
        checks++;
        if (ifA.swap_pending !== 1'b1 || ifA.frame_cnt !== 8'd3) begin
            errors++;
            $display("[TB] FAIL coincident_no_swap: got pend=%b cnt=%0d expected 1/3", ifA.swap_pending, ifA.frame_cnt);
        end
        tick();
        tick();
        checks++;
        if (ifA.frame_out !== 512'd0) begin
            errors++;
            $display("[TB] FAIL coincident_hold: got %h expected 0", ifA.frame_out);
        end
        swapA();
        checks++;
        if (ifA.frame_out !== exp || ifA.frame_cnt !== 8'd4) begin
            errors++;
            $display("[TB] FAIL coincident_swap: got cnt=%0d frame=%h expected 4/%h", ifA.frame_cnt, ifA.frame_out, exp);
        end
        for (int i = 0; i < 64; i++) tick();
    endtask

    task automatic test_pending_write();
        logic [511:0] exp;
        exp = '0;
        exp[8*3 +: 8] = 8'h77;
        wrA(6'd3, 8'h77);
        commitA();
        ifA.wr_valid     = 1'b1;
        ifA.wr_addr      = 6'd3;
        ifA.wr_data      = 8'hFF;
        ifA.commit_valid = 1'b1;
        #1;
        checks++;
        if (ifA.wr_ready !== 1'b0 || ifA.commit_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pending_ready: got %b%b expected 00", ifA.wr_ready, ifA.commit_ready);
        end
        tick();
        tick();
        ifA.wr_valid     = 1'b0;
        ifA.commit_valid = 1'b0;
        swapA();
        checks++;
        if (ifA.frame_out !== exp || ifA.frame_cnt !== 8'd5) begin
            errors++;
            $display("[TB] FAIL pending_write_ignored: got cnt=%0d frame=%h expected 5/%h", ifA.frame_cnt, ifA.frame_out, exp);
        end
    endtask

    task automatic test_reset_mid();
        // Currently 1 cycle into CLEAR after swap 5.
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (ifA.frame_out !== 512'd0 || ifA.frame_cnt !== 8'd0 || ifA.swap_pending !== 1'b0 || ifA.wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_clear: got cnt=%0d pend=%b rdy=%b frame=%h expected all 0", ifA.frame_cnt, ifA.swap_pending, ifA.wr_ready, ifA.frame_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ifA.wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_clear_to_fill: got %b expected 1", ifA.wr_ready);
        end
        wrA(6'd0, 8'h3C);
        commitA();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        swapA();
        checks++;
        if (ifA.frame_out !== 512'd0 || ifA.frame_cnt !== 8'd0 || ifA.swap_pending !== 1'b0 || ifA.wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_pending: got cnt=%0d pend=%b rdy=%b frame=%h expected 0/0/1/0", ifA.frame_cnt, ifA.swap_pending, ifA.wr_ready, ifA.frame_out);
        end
    endtask

    task automatic test_no_clear();
        logic [511:0] exp;
        doReset();
        wrB(6'd0, 8'hAA);
        commitSwapB();
        checks++;
        if (ifB.wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL noclear_ready: got %b expected 1", ifB.wr_ready);
        end
        wrB(6'd1, 8'h55);
        commitSwapB();
        exp = '0;
        exp[15:8] = 8'h55;
        checks++;
        if (ifB.frame_out !== exp) begin
            errors++;
            $display("[TB] FAIL noclear_frame2: got %h expected %h", ifB.frame_out, exp);
        end
        commitSwapB();
        exp = '0;
        exp[7:0] = 8'hAA;
        checks++;
        if (ifB.frame_out !== exp || ifB.frame_cnt !== 8'd3) begin
            errors++;
            $display("[TB] FAIL noclear_frame3: got cnt=%0d frame=%h expected 3/%h", ifB.frame_cnt, ifB.frame_out, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] exp;
        logic [7:0]   data;
        int           slot;
        doReset();
        for (int n = 1; n <= 256; n++) begin
            slot = n % 64;
            data = 8'(n) ^ 8'h5A;
            exp = '0;
            exp[8*slot +: 8] = data;
            wrA(6'(slot), data);
            commitA();
            swapA();
            checks++;
            if (ifA.frame_out !== exp || ifA.frame_cnt !== 8'(n)) begin
                errors++;
                $display("[TB] FAIL wrap_swap_%0d: got cnt=%0d frame=%h expected %0d/%h", n, ifA.frame_cnt, ifA.frame_out, 8'(n), exp);
            end
            for (int i = 0; i < 64; i++) tick();
            checks++;
            if (ifA.frame_out !== exp) begin
                errors++;
                $display("[TB] FAIL wrap_hold_%0d: got %h expected %h", n, ifA.frame_out, exp);
            end
        end
        checks++;
        if (ifA.frame_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL frame_cnt_wrap: got %0d expected 0", ifA.frame_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifA.wr_valid = 1'b0; ifA.wr_addr = '0; ifA.wr_data = '0;
        ifA.commit_valid = 1'b0; ifA.swap_sync = 1'b0;
        ifB.wr_valid = 1'b0; ifB.wr_addr = '0; ifB.wr_data = '0;
        ifB.commit_valid = 1'b0; ifB.swap_sync = 1'b0;
        test_reset();
        test_fill_swap();
        test_empty_commit();
        test_coincident();
        test_pending_write();
        test_reset_mid();
        test_no_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
